// File: rtl/reg_file_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mem_if
//  Description : Bus bundle for reg_file_mem. Carries the write port, the two
//                read ports and the clear/status handshake.
//                master : drives write/read addresses, write data and clear;
//                         observes read data, busy, wr_ack and wr_err.
//                slave  : the storage array itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface reg_file_mem_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [AW-1:0]     rd_addr_a;
    logic [AW-1:0]     rd_addr_b;
    logic [WIDTH-1:0]  rd_data_a;
    logic [WIDTH-1:0]  rd_data_b;
    logic              clear;
    logic              busy;
    logic              wr_ack;
    logic              wr_err;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clear,
        input  rd_data_a, rd_data_b, busy, wr_ack, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clear,
        output rd_data_a, rd_data_b, busy, wr_ack, wr_err
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_mem.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mem
//  Description : DEPTH x WIDTH register-file storage with one synchronous
//                write port and two registered (latency 1) read ports.
//                A write landing on the same edge as a read of that address
//                is forwarded to the read (write-first). A clear sweep
//                rewrites the array with RESET_VALUE one word per cycle.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - reg_file_mem_if.slave:
//                       wr_en/wr_addr/wr_data  write request
//                       rd_addr_a/rd_addr_b    read addresses
//                       rd_data_a/rd_data_b    registered read data
//                       clear                  start a clear sweep
//                       busy                   sweep in progress
//                       wr_ack / wr_err        1-cycle write result pulses
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file_mem #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    reg_file_mem_if.slave     bus
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Depth held one bit wider than an address so that the range compare
    // also works when DEPTH is an exact power of two.
    localparam logic [AW:0]     DEPTH_X  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     ptr_q;
    logic              busy_q;
    logic              wr_ack_q;
    logic              wr_err_q;
    logic [WIDTH-1:0]  rd_data_a_q;
    logic [WIDTH-1:0]  rd_data_b_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              w_wr_in_range;
    logic              w_port_wr;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [WIDTH-1:0]  w_wdata;
    logic [WIDTH-1:0]  rd_data_a_d;
    logic [WIDTH-1:0]  rd_data_b_d;

    assign w_wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_X);
    assign w_port_wr     = bus.wr_en && (state_q == S_IDLE) && w_wr_in_range;

    // The sweep and the port never write on the same edge: port writes are
    // only taken in IDLE and the sweep only runs in CLEAR.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = bus.wr_addr;
        w_wdata = bus.wr_data;
        if (state_q == S_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = ptr_q;
            w_wdata = RESET_VALUE;
        end else if (w_port_wr) begin
            w_we    = 1'b1;
        end
    end

    // Next read data with write-first forwarding; out-of-range reads give 0.
    always_comb begin
        rd_data_a_d = '0;
        rd_data_b_d = '0;
        if ({1'b0, bus.rd_addr_a} < DEPTH_X) begin
            if (w_we && (w_waddr == bus.rd_addr_a)) rd_data_a_d = w_wdata;
            else                                    rd_data_a_d = mem_q[bus.rd_addr_a];
        end
        if ({1'b0, bus.rd_addr_b} < DEPTH_X) begin
            if (w_we && (w_waddr == bus.rd_addr_b)) rd_data_b_d = w_wdata;
            else                                    rd_data_b_d = mem_q[bus.rd_addr_b];
        end
    end

    // Storage array. w_waddr is always in range whenever w_we is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VALUE;
            end
        end else if (w_we) begin
            mem_q[w_waddr] <= w_wdata;
        end
    end

    // Read data registers. Reset loads RESET_VALUE, matching the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_a_q <= RESET_VALUE;
            rd_data_b_q <= RESET_VALUE;
        end else begin
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
        end
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.wr_en) begin
                        wr_ack_q <= w_wr_in_range;
                        wr_err_q <= !w_wr_in_range;
                    end
                    // A write taken on this edge lands first; the sweep
                    // then wipes it along with everything else.
                    if (bus.clear) begin
                        state_q <= S_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    // Writes and further clear requests are dropped here.
                    if (ptr_q == LAST_PTR) begin
                        state_q <= S_IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q   <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data_a = rd_data_a_q;
    assign bus.rd_data_b = rd_data_b_q;
    assign bus.busy      = busy_q;
    assign bus.wr_ack    = wr_ack_q;
    assign bus.wr_err    = wr_err_q;

endmodule
`default_nettype wire
